// File: rtl/msg_byte_sequencer.sv
// msg_byte_sequencer: buffers a message byte-by-byte, then replays it into the
// bit-sum Adder. It sequences the Adder's state code, waits for fine, and
// captures the 13-bit sum as the message result.
module msg_byte_sequencer #(
  parameter int DEPTH   = 64,
  parameter int AW      = 6,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  output logic          wr_ready,
  input  logic          start,
  output logic          busy,
  output logic [AW:0]   msg_len,
  output logic          adder_reset,
  output logic [1:0]    state_out,
  output logic [7:0]    byte_out,
  input  logic          adder_fine,
  input  logic [12:0]   adder_sum,
  output logic [12:0]   result,
  output logic          done,
  output logic          err
);

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RST  = 3'd1;
  localparam logic [2:0] S_CLR  = 3'd2;
  localparam logic [2:0] S_RUN  = 3'd3;
  localparam logic [2:0] S_OUT  = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  // Adder state codes.
  localparam logic [1:0] A_IDLE = 2'b00;
  localparam logic [1:0] A_CLR  = 2'b01;
  localparam logic [1:0] A_ACC  = 2'b10;
  localparam logic [1:0] A_OUT  = 2'b11;

  logic [2:0]    state;
  logic [AW:0]   count;     // bytes buffered
  logic [AW:0]   run_len;   // N latched at start
  logic [AW:0]   rd_ptr;    // index of the next byte to present
  logic [TW-1:0] tcnt;      // cycles spent waiting in OUT
  logic [7:0]    mem [0:DEPTH-1];
  logic          wr_acc;

  assign wr_ready = (state == S_IDLE) && (count < (AW+1)'(DEPTH));
  assign wr_acc   = wr_en && wr_ready;
  assign busy     = (state != S_IDLE);
  assign msg_len  = count;

  // Message buffer: store an accepted byte at the current write position.
  // NOTE: the storage array has no reset; count alone decides which entries
  // are valid, so clearing the data would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[count[AW-1:0]] <= wr_data;
  end

  // Control FSM; every Adder-facing output is registered here so
  // adder_reset, state_out and byte_out always change on the same edge.
  // NOTE: all state in this block uses non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      count       <= '0;
      run_len     <= '0;
      rd_ptr      <= '0;
      tcnt        <= '0;
      adder_reset <= 1'b0;
      state_out   <= A_IDLE;
      byte_out    <= '0;
      result      <= '0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      adder_reset <= 1'b0;
      done        <= 1'b0;
      case (state)
        S_IDLE: begin
          if (wr_acc) count <= count + 1'b1;
          if (start) begin
            // A byte accepted in the start cycle belongs to this run.
            run_len     <= count + (AW+1)'(wr_acc);
            err         <= 1'b0;
            adder_reset <= 1'b1;
            state_out   <= A_IDLE;
            state       <= S_RST;
          end
        end
        S_RST: begin
          state_out <= A_CLR;
          state     <= S_CLR;
        end
        S_CLR: begin
          tcnt <= '0;
          if (run_len != '0) begin
            state_out <= A_ACC;
            byte_out  <= mem[0];
            rd_ptr    <= (AW+1)'(1);
            state     <= S_RUN;
          end else begin
            state_out <= A_OUT;
            state     <= S_OUT;
          end
        end
        S_RUN: begin
          if (rd_ptr == run_len) begin
            state_out <= A_OUT;
            byte_out  <= '0;
            state     <= S_OUT;
          end else begin
            byte_out <= mem[rd_ptr[AW-1:0]];
            rd_ptr   <= rd_ptr + 1'b1;
          end
        end
        S_OUT: begin
          if (adder_fine || (tcnt == TW'(TIMEOUT - 1))) begin
            result    <= adder_fine ? adder_sum : 13'd0;
            err       <= !adder_fine;
            done      <= 1'b1;
            state_out <= A_IDLE;
            count     <= '0;
            rd_ptr    <= '0;
            state     <= S_DONE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_msg_byte_sequencer.sv
// Self-checking bench for msg_byte_sequencer with a behavioural Adder model
// and a queue-based reference of the buffered message.
module tb_msg_byte_sequencer;

  localparam int DEPTH   = 64;
  localparam int AW      = 6;
  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [7:0]  wr_data;
  logic        wr_ready;
  logic        start;
  logic        busy;
  logic [AW:0] msg_len;
  logic        adder_reset;
  logic [1:0]  state_out;
  logic [7:0]  byte_out;
  logic        adder_fine;
  logic [12:0] adder_sum;
  logic [12:0] result;
  logic        done;
  logic        err;

  int errors = 0;
  int checks = 0;

  logic [7:0] q[$];     // reference copy of the buffered message
  logic [12:0] m_sum;   // Adder model
  logic        m_fine;
  bit          adder_ok = 1'b1;
  logic [12:0] last_result = '0;

  always #5 clk = ~clk;

  msg_byte_sequencer #(.DEPTH(DEPTH), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
    .wr_ready(wr_ready), .start(start), .busy(busy), .msg_len(msg_len),
    .adder_reset(adder_reset), .state_out(state_out), .byte_out(byte_out),
    .adder_fine(adder_fine), .adder_sum(adder_sum), .result(result),
    .done(done), .err(err)
  );

  // Companion Adder: counts set bits, fine is sticky until its reset.
  always @(posedge clk) begin
    if (reset || adder_reset) begin
      m_sum  <= '0;
      m_fine <= 1'b0;
    end else begin
      case (state_out)
        2'b01:   m_sum  <= '0;
        2'b10:   m_sum  <= m_sum + 13'($countones(byte_out));
        2'b11:   m_fine <= 1'b1;
        default: ;
      endcase
    end
  end
  assign adder_fine = adder_ok && m_fine;
  assign adder_sum  = m_sum;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".wr_ready"},    32'(wr_ready),    32'd1);
    check({tag, ".busy"},        32'(busy),        32'd0);
    check({tag, ".msg_len"},     32'(msg_len),     32'd0);
    check({tag, ".adder_reset"}, 32'(adder_reset), 32'd0);
    check({tag, ".state_out"},   32'(state_out),   32'd0);
    check({tag, ".byte_out"},    32'(byte_out),    32'd0);
    check({tag, ".result"},      32'(result),      32'd0);
    check({tag, ".done"},        32'(done),        32'd0);
    check({tag, ".err"},         32'(err),         32'd0);
  endtask

  // Called and returns at a negedge while idle.
  task automatic write_byte(input logic [7:0] b);
    bit acc;
    acc = (q.size() < DEPTH);
    check("wr_ready", 32'(wr_ready), 32'(acc));
    wr_en = 1'b1; wr_data = b;
    @(negedge clk);
    wr_en = 1'b0;
    if (acc) q.push_back(b);
    check("msg_len", 32'(msg_len), 32'(q.size()));
  endtask

  // Runs the buffered message and checks the whole cycle-by-cycle trace.
  task automatic run_msg(input bit fine_ok, input bit wr_with_start,
                         input logic [7:0] wr_b, input bit poke_busy,
                         input string tag);
    int n, out_len, done_k, pop;
    logic [12:0] exp_res;
    logic [1:0]  exp_st;
    adder_ok = fine_ok;
    start = 1'b1;
    if (wr_with_start) begin
      wr_en = 1'b1; wr_data = wr_b;
      if (q.size() < DEPTH) q.push_back(wr_b);
    end
    n = q.size();
    pop = 0;
    foreach (q[i]) pop += $countones(q[i]);
    exp_res = fine_ok ? 13'(pop) : 13'd0;
    out_len = fine_ok ? 2 : TIMEOUT;
    done_k  = n + 3 + out_len;
    @(negedge clk);
    start = 1'b0; wr_en = 1'b0;
    for (int k = 1; k <= done_k + 1; k++) begin
      if (k == 1)             exp_st = 2'b00;
      else if (k == 2)        exp_st = 2'b01;
      else if (k <= n + 2)    exp_st = 2'b10;
      else if (k < done_k)    exp_st = 2'b11;
      else                    exp_st = 2'b00;
      check({tag, ".state_out"},   32'(state_out),   32'(exp_st));
      check({tag, ".adder_reset"}, 32'(adder_reset), 32'(k == 1));
      check({tag, ".done"},        32'(done),        32'(k == done_k));
      check({tag, ".busy"},        32'(busy),        32'(k <= done_k));
      if (k >= 3 && k <= n + 2)
        check({tag, ".byte_out"}, 32'(byte_out), 32'(q[k-3]));
      if (k == 1) check({tag, ".err_cleared"}, 32'(err), 32'd0);
      if (k == done_k) begin
        check({tag, ".result"}, 32'(result), 32'(exp_res));
        check({tag, ".err"},    32'(err),    32'(!fine_ok));
      end
      if (k == done_k + 1) begin
        check({tag, ".msg_len_after"},  32'(msg_len),  32'd0);
        check({tag, ".wr_ready_after"}, 32'(wr_ready), 32'd1);
        check({tag, ".result_hold"},    32'(result),   32'(exp_res));
        check({tag, ".err_hold"},       32'(err),      32'(!fine_ok));
      end
      if (poke_busy && k == 2) begin
        check({tag, ".wr_ready_busy"}, 32'(wr_ready), 32'd0);
        start = 1'b1; wr_en = 1'b1; wr_data = 8'($urandom);
      end
      if (poke_busy && k == 3) begin
        start = 1'b0; wr_en = 1'b0;
        check({tag, ".msg_len_busy"}, 32'(msg_len), 32'(n));
      end
      if (k <= done_k) @(negedge clk);
    end
    q.delete();
    last_result = exp_res;
    adder_ok = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_data = '0; start = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    reset = 1'b0;
    @(negedge clk);

    // Basic three-byte message: 8 + 1 + 1 set bits.
    write_byte(8'hFF); write_byte(8'h01); write_byte(8'h80);
    run_msg(1'b1, 1'b0, 8'h00, 1'b0, "basic");
    check("basic_sum", 32'(last_result), 32'd10);

    // Empty message skips the accumulate phase.
    run_msg(1'b1, 1'b0, 8'h00, 1'b0, "empty");

    // Full buffer, overflow byte dropped.
    for (int i = 0; i < DEPTH; i++) write_byte(8'hFF);
    check("full_wr_ready", 32'(wr_ready), 32'd0);
    write_byte(8'hFF);
    check("full_msg_len", 32'(msg_len), 32'(DEPTH));
    run_msg(1'b1, 1'b0, 8'h00, 1'b0, "full");
    check("full_sum", 32'(last_result), 32'd512);

    // Adder never answers: timeout, then a clean run clears err.
    write_byte(8'hA5);
    run_msg(1'b0, 1'b0, 8'h00, 1'b0, "timeout");
    write_byte(8'h0F);
    run_msg(1'b1, 1'b0, 8'h00, 1'b0, "recover");
    check("recover_sum", 32'(last_result), 32'd4);

    // Reset asserted during RUN of a 10-byte message.
    for (int i = 0; i < 10; i++) write_byte(8'($urandom));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_state_run", 32'(state_out), 32'd2);
    reset = 1'b1;
    @(negedge clk);
    check_reset_values("midreset");
    reset = 1'b0;
    q.delete();
    repeat (6) begin
      @(negedge clk);
      check("midreset_no_done", 32'(done), 32'd0);
    end
    write_byte(8'h03);
    run_msg(1'b1, 1'b0, 8'h00, 1'b0, "after_reset");
    check("after_reset_sum", 32'(last_result), 32'd2);

    // Back-to-back runs with start and writes poked while busy.
    write_byte(8'h07);
    run_msg(1'b1, 1'b0, 8'h00, 1'b1, "b2b_a");
    check("b2b_a_sum", 32'(last_result), 32'd3);
    write_byte(8'hF0); write_byte(8'hF0);
    run_msg(1'b1, 1'b0, 8'h00, 1'b1, "b2b_b");
    check("b2b_b_sum", 32'(last_result), 32'd8);

    // Randomized messages, optionally writing a byte in the start cycle.
    for (int r = 0; r < 12; r++) begin
      int len;
      len = int'($urandom_range(0, 9));
      for (int i = 0; i < len; i++) write_byte(8'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_msg(1'b1, 1'($urandom_range(0, 1)), 8'($urandom),
              1'($urandom_range(0, 1)), "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
